// File: rtl/input_debouncer_pkg.sv
// Shared definitions for the input debouncer.
//   dbnc_state_e : per-bit FSM state encoding (StStable, StSettling)
//   cnt_width()  : width of the per-bit stability counter for a given cycle count
package input_debouncer_pkg;

  typedef enum logic {
    StStable   = 1'b0,
    StSettling = 1'b1
  } dbnc_state_e;

  // Counter only has to reach cycles-1; illegal counts (<2) still get a
  // 1-bit counter so elaboration reaches the explicit parameter error.
  function automatic int unsigned cnt_width(int unsigned cycles);
    return (cycles < 2) ? 1 : $clog2(cycles);
  endfunction

endpackage

// File: rtl/debounce_bit.sv
// Single-bit debouncer: 2-FF synchroniser, stability FSM/counter and
// registered rise/fall pulse generation.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   din   : raw asynchronous input bit
//   dout  : debounced level
//   rise  : one-cycle pulse coincident with dout going 0->1
//   fall  : one-cycle pulse coincident with dout going 1->0
module debounce_bit
  import input_debouncer_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall
);

  localparam int unsigned CntW = cnt_width(STABLE_CYCLES);
  localparam logic [CntW-1:0] CntMax = CntW'(STABLE_CYCLES - 1);

  dbnc_state_e     state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            s1_q, s2_q;
  logic            out_q, out_d;
  logic            rise_q, rise_d;
  logic            fall_q, fall_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      state_q <= StStable;
      cnt_q   <= '0;
      out_q   <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      s1_q    <= din;
      s2_q    <= s1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    out_d   = out_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    unique case (state_q)
      StStable: begin
        if (s2_q != out_q) begin
          state_d = StSettling;
          cnt_d   = CntW'(1);
        end
      end
      StSettling: begin
        if (s2_q == out_q) begin
          // Input bounced back before it was stable long enough.
          state_d = StStable;
        end else if (cnt_q == CntMax) begin
          state_d = StStable;
          out_d   = s2_q;
          rise_d  = s2_q;
          fall_d  = ~s2_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    endcase
  end

  assign dout = out_q;
  assign rise = rise_q;
  assign fall = fall_q;

endmodule

// File: rtl/input_debouncer.sv
// Multi-bit input debouncer for raw board inputs (buttons, switches, GPIO).
// Each bit is synchronised and debounced independently by debounce_bit.
// Optional sticky event latch enabled by defining DEBOUNCE_EVENT_LATCH_EN;
// without it evt/irq are tied low and evt_clr is ignored.
// Ports:
//   clk     : system clock, rising edge
//   rst_n   : asynchronous active-low reset
//   in      : raw asynchronous inputs
//   out     : debounced levels
//   rise    : one-cycle pulse per bit on 0->1
//   fall    : one-cycle pulse per bit on 1->0
//   evt_clr : write-1-to-clear for sticky event flags
//   evt     : sticky event flags (set on any rise/fall)
//   irq     : OR of evt
module input_debouncer
  import input_debouncer_pkg::*;
#(
  parameter int unsigned WIDTH         = 4,
  parameter int unsigned STABLE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  input  logic [WIDTH-1:0] evt_clr,
  output logic [WIDTH-1:0] evt,
  output logic             irq
);

  if (STABLE_CYCLES < 2) begin : gen_param_check
    $error("input_debouncer: STABLE_CYCLES must be >= 2");
  end

  for (genvar i = 0; i < WIDTH; i++) begin : gen_bit
    debounce_bit #(
      .STABLE_CYCLES(STABLE_CYCLES)
    ) u_bit (
      .clk  (clk),
      .rst_n(rst_n),
      .din  (in[i]),
      .dout (out[i]),
      .rise (rise[i]),
      .fall (fall[i])
    );
  end

`ifdef DEBOUNCE_EVENT_LATCH_EN
  logic [WIDTH-1:0] evt_q, evt_d;

  // Set has priority over a same-cycle clear.
  always_comb begin
    evt_d = (evt_q & ~evt_clr) | rise | fall;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      evt_q <= '0;
    end else begin
      evt_q <= evt_d;
    end
  end

  assign evt = evt_q;
  assign irq = |evt_q;
`else
  logic unused_evt_clr;
  assign unused_evt_clr = ^evt_clr;
  assign evt = '0;
  assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_input_debouncer.sv
// Self-checking bench for input_debouncer (WIDTH=4, STABLE_CYCLES=4).
// Reference model: out[i] flips when the last STABLE_CYCLES synchronised
// samples of bit i all differ from out[i].
module tb_input_debouncer;

  localparam int unsigned W = 4;
  localparam int unsigned N = 4;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] din;
  logic [W-1:0] evt_clr;
  logic [W-1:0] out, rise, fall, evt;
  logic         irq;

  input_debouncer #(
    .WIDTH        (W),
    .STABLE_CYCLES(N)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .in     (din),
    .out    (out),
    .rise   (rise),
    .fall   (fall),
    .evt_clr(evt_clr),
    .evt    (evt),
    .irq    (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [W-1:0] s1_m, s2_m, out_m, rise_m, fall_m, evt_m;
  logic         irq_m;
  logic [N-1:0] hist [W];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    s1_m = '0; s2_m = '0; out_m = '0; rise_m = '0; fall_m = '0; evt_m = '0; irq_m = 1'b0;
    for (int i = 0; i < W; i++) hist[i] = '0;
  endtask

  task automatic model_edge();
`ifdef DEBOUNCE_EVENT_LATCH_EN
    evt_m = (evt_m & ~evt_clr) | rise_m | fall_m;
`else
    evt_m = '0;
`endif
    rise_m = '0;
    fall_m = '0;
    for (int i = 0; i < W; i++) begin
      hist[i] = {hist[i][N-2:0], s2_m[i]};
      if (hist[i] == {N{~out_m[i]}}) begin
        out_m[i]  = ~out_m[i];
        rise_m[i] = out_m[i];
        fall_m[i] = ~out_m[i];
      end
    end
    s2_m  = s1_m;
    s1_m  = din;
    irq_m = |evt_m;
  endtask

  task automatic compare_all();
    check("out", 32'(out), 32'(out_m));
    check("rise", 32'(rise), 32'(rise_m));
    check("fall", 32'(fall), 32'(fall_m));
    check("rise_and_fall", 32'(rise & fall), 32'd0);
    check("evt", 32'(evt), 32'(evt_m));
    check("irq", 32'(irq), 32'(irq_m));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  // Asynchronous reset asserted mid-cycle; checks the immediate clear.
  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_out", 32'(out), 32'd0);
    check("rst_rise", 32'(rise | fall), 32'd0);
    check("rst_evt", 32'({irq, evt}), 32'd0);
    model_reset();
    @(posedge clk);
    #3;
    rst_n = 1'b1;
  endtask

  task automatic settle_low();
    din = '0;
    for (int k = 0; k < 2 * N; k++) step();
  endtask

  initial begin
    rst_n   = 1'b0;
    din     = '1;
    evt_clr = '0;
    model_reset();
    #12;
    check("reset_out", 32'(out), 32'd0);
    check("reset_pulses", 32'(rise | fall), 32'd0);
    @(posedge clk);
    #3;
    rst_n = 1'b1;

    // Reset release with all inputs high: 6-edge latency.
    for (int k = 1; k <= N + 1; k++) begin
      step();
      check("latency_out_low", 32'(out), 32'd0);
    end
    step();
    check("latency_out_high", 32'(out), 32'hF);
    check("latency_rise", 32'(rise), 32'hF);
    step();
    check("rise_one_cycle", 32'(rise), 32'd0);

    // Glitch of N-1 cycles on bit 0.
    settle_low();
    din[0] = 1'b1;
    for (int k = 0; k < N - 1; k++) step();
    din[0] = 1'b0;
    for (int k = 0; k < 2 * N; k++) begin
      step();
      check("glitch_out0", 32'(out[0]), 32'd0);
      check("glitch_pulse0", 32'(rise[0] | fall[0]), 32'd0);
    end

    // Clean press/release on bit 1.
    din[1] = 1'b1;
    for (int k = 1; k <= N + 2; k++) begin
      step();
      check("press_rise1", 32'(rise[1]), 32'(k == N + 2));
    end
    for (int k = 0; k < 10 - (N + 2); k++) step();
    din[1] = 1'b0;
    for (int k = 1; k <= N + 3; k++) begin
      step();
      check("release_fall1", 32'(fall[1]), 32'(k == N + 2));
    end

    // Reset in the middle of a settle on bit 2.
    settle_low();
    din[2] = 1'b1;
    for (int k = 0; k < 4; k++) step();
    do_reset();
    for (int k = 1; k <= N + 1; k++) begin
      step();
      check("midrst_out2_low", 32'(out[2]), 32'd0);
    end
    step();
    check("midrst_out2_high", 32'(out[2]), 32'd1);

    // Independence: bits 0/2 then bits 1/3 two cycles later.
    settle_low();
    din = 4'b0101;
    step();
    step();
    din = 4'b1111;
    for (int k = 3; k <= N + 2; k++) step();
    check("indep_first", 32'(out), 32'b0101);
    step();
    step();
    check("indep_second", 32'(out), 32'b1111);

`ifdef DEBOUNCE_EVENT_LATCH_EN
    settle_low();
    evt_clr = '1;
    step();
    evt_clr = '0;
    din[3] = 1'b1;
    for (int k = 0; k < N + 3; k++) step();
    check("evt_press", 32'(evt), 32'b1000);
    check("irq_press", 32'(irq), 32'd1);
    din[3] = 1'b0;
    for (int k = 0; k < N + 2; k++) step();
    check("evt_fall_pulse", 32'(fall[3]), 32'd1);
    evt_clr[3] = 1'b1;
    step();
    evt_clr[3] = 1'b0;
    check("evt_set_wins", 32'(evt), 32'b1000);
    evt_clr[3] = 1'b1;
    step();
    evt_clr[3] = 1'b0;
    check("evt_cleared", 32'({irq, evt}), 32'd0);
`endif

    // Randomised stimulus against the model.
    for (int k = 0; k < 600; k++) begin
      for (int i = 0; i < W; i++) begin
        if ($urandom_range(0, 5) == 0) din[i] = ~din[i];
        evt_clr[i] = ($urandom_range(0, 3) == 0);
      end
      if ($urandom_range(0, 149) == 0) do_reset();
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
